// File: rtl/bw_clk_cl_hdr_seq.sv
// N-cluster clock-header sequencer: staggered per-cluster clock enables, timed
// per-cluster reset release, and a gated debug-init pulse, with a scan chain through the enables.
module bw_clk_cl_hdr_seq #(
    parameter int NUM_CL    = 4,
    parameter int STAGGER   = 4,
    parameter int RST_HOLD  = 8,
    parameter int DBG_PULSE = 3
) (
    input  logic              i_gclk,
    input  logic              i_grst,
    input  logic              i_cken_req,
    input  logic [NUM_CL-1:0] i_cluster_mask,
    input  logic              i_dbginit_req,
    input  logic              i_si,
    input  logic              i_se,
    output logic [NUM_CL-1:0] o_cluster_cken,
    output logic [NUM_CL-1:0] o_cluster_grst_l,
    output logic [NUM_CL-1:0] o_dbginit_l,
    output logic              o_busy,
    output logic              o_so
);

    localparam int SW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam int RW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam int PW = (DBG_PULSE > 1) ? $clog2(DBG_PULSE) : 1;
    localparam logic [SW-1:0] STAG_LAST = SW'(STAGGER - 1);
    localparam logic [RW-1:0] RH_LAST   = RW'(RST_HOLD - 1);
    localparam logic [PW-1:0] PL_LAST   = PW'(DBG_PULSE - 1);

    typedef enum logic [1:0] {S_IDLE, S_RAMP_UP, S_ON, S_RAMP_DOWN} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SW-1:0]     r_stag;
    logic [NUM_CL-1:0] r_cken;
    logic [NUM_CL-1:0] r_grst_l;
    logic [NUM_CL-1:0] r_dbginit_l;
    logic [RW-1:0]     r_rcnt [NUM_CL];
    logic              r_dbg_pend;
    logic              r_pulse;
    logic [PW-1:0]     r_pcnt;

    logic              w_boundary;
    logic              w_busy_cur;
    logic              w_busy_nxt;
    logic              w_dbg_accept;
    logic              w_pulse_nxt;
    logic [NUM_CL-1:0] w_lo_cand;
    logic [NUM_CL-1:0] w_hi_on;
    logic [NUM_CL-1:0] w_cken_step;
    logic [NUM_CL-1:0] w_shift;
    logic [NUM_CL-1:0] w_cken_nxt;

    // Lowest enable candidate, highest running cluster, and the scan-shifted enable vector.
    always_comb begin
        w_lo_cand = '0;
        w_hi_on   = '0;
        w_shift   = '0;
        for (int i = NUM_CL - 1; i >= 0; i--) begin
            if (i_cluster_mask[i] && !r_cken[i]) begin
                w_lo_cand    = '0;
                w_lo_cand[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_CL; i++) begin
            if (r_cken[i]) begin
                w_hi_on    = '0;
                w_hi_on[i] = 1'b1;
            end
        end
        w_shift[0] = i_si;
        for (int i = 1; i < NUM_CL; i++) begin
            w_shift[i] = r_cken[i-1];
        end
    end

    always_ff @(posedge i_gclk) begin
        if (i_grst) begin
            r_state <= S_IDLE;
        end else if (!i_se) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cken_step = r_cken;
        w_boundary  = (r_stag == '0);
        case (r_state)
            S_IDLE: begin
                if (i_cken_req) w_state_nxt = S_RAMP_UP;
            end
            S_RAMP_UP: begin
                if (w_boundary) begin
                    if (!i_cken_req) begin
                        w_state_nxt = S_RAMP_DOWN;
                        w_cken_step = r_cken & ~w_hi_on;
                    end else if (w_lo_cand == '0) begin
                        w_state_nxt = S_ON;
                    end else begin
                        w_cken_step = r_cken | w_lo_cand;
                    end
                end
            end
            S_ON: begin
                if (!i_cken_req) w_state_nxt = S_RAMP_DOWN;
            end
            S_RAMP_DOWN: begin
                if (w_boundary) begin
                    if (i_cken_req) begin
                        w_state_nxt = S_RAMP_UP;
                        w_cken_step = r_cken | w_lo_cand;
                    end else if (r_cken == '0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cken_step = r_cken & ~w_hi_on;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_cken_nxt = i_se ? w_shift : w_cken_step;
    end

    always_comb begin
        w_busy_cur = (r_state == S_RAMP_UP) || (r_state == S_RAMP_DOWN);
        w_busy_nxt = (w_state_nxt == S_RAMP_UP) || (w_state_nxt == S_RAMP_DOWN);
        o_busy     = w_busy_cur;
        o_so       = r_cken[NUM_CL-1];
    end

    // Slot timer runs only across consecutive ramp cycles, so each new ramp starts on slot 0.
    always_ff @(posedge i_gclk) begin
        if (i_grst) begin
            r_stag <= '0;
        end else if (!i_se) begin
            if (w_busy_cur && w_busy_nxt) begin
                r_stag <= (r_stag == STAG_LAST) ? '0 : r_stag + SW'(1);
            end else begin
                r_stag <= '0;
            end
        end
    end

    always_ff @(posedge i_gclk) begin
        if (i_grst) begin
            r_cken <= '0;
        end else begin
            r_cken <= w_cken_nxt;
        end
    end

    // Reset release: a fresh enable restarts the count, a disable drops reset on the same edge.
    always_ff @(posedge i_gclk) begin
        if (i_grst) begin
            r_grst_l <= '0;
            for (int i = 0; i < NUM_CL; i++) r_rcnt[i] <= '0;
        end else if (!i_se) begin
            for (int i = 0; i < NUM_CL; i++) begin
                if (!w_cken_nxt[i] || !r_cken[i]) begin
                    r_grst_l[i] <= 1'b0;
                    r_rcnt[i]   <= '0;
                end else if (!r_grst_l[i]) begin
                    if (r_rcnt[i] == RH_LAST) r_grst_l[i] <= 1'b1;
                    else                      r_rcnt[i]   <= r_rcnt[i] + RW'(1);
                end
            end
        end
    end

    always_comb begin
        w_dbg_accept = (r_state == S_ON) && i_dbginit_req && !r_pulse && !r_dbg_pend;
        w_pulse_nxt  = i_se ? r_pulse : (r_dbg_pend || (r_pulse && (r_pcnt != '0)));
    end

    always_ff @(posedge i_gclk) begin
        if (i_grst) begin
            r_dbg_pend  <= 1'b0;
            r_pulse     <= 1'b0;
            r_pcnt      <= '0;
            r_dbginit_l <= '1;
        end else if (!i_se) begin
            r_dbg_pend  <= w_dbg_accept;
            r_pulse     <= w_pulse_nxt;
            r_dbginit_l <= ~({NUM_CL{w_pulse_nxt}} & w_cken_nxt);
            if (r_dbg_pend)                 r_pcnt <= PL_LAST;
            else if (r_pulse && r_pcnt != 0) r_pcnt <= r_pcnt - PW'(1);
        end
    end

    assign o_cluster_cken   = r_cken;
    assign o_cluster_grst_l = r_grst_l;
    assign o_dbginit_l      = r_dbginit_l;

endmodule

// File: tb/tb_bw_clk_cl_hdr_seq.sv
// Scoreboard bench for bw_clk_cl_hdr_seq at default parameters: expected per-cycle
// outputs are queued when a scenario is driven and popped after every clock edge.
module tb_bw_clk_cl_hdr_seq;

    typedef struct packed {
        logic [3:0] cken;
        logic [3:0] grst_l;
        logic [3:0] dbg_l;
        logic       busy;
        logic       so;
    } obs_t;

    logic       gclk = 1'b0;
    logic       grst;
    logic       ckenReq;
    logic [3:0] clusterMask;
    logic       dbginitReq;
    logic       si;
    logic       se;
    logic [3:0] clusterCken;
    logic [3:0] clusterGrstL;
    logic [3:0] dbginitL;
    logic       busy;
    logic       so;

    obs_t expQ[$];
    int   nChecks = 0;
    int   nFail   = 0;

    bw_clk_cl_hdr_seq dut (
        .i_gclk          (gclk),
        .i_grst          (grst),
        .i_cken_req      (ckenReq),
        .i_cluster_mask  (clusterMask),
        .i_dbginit_req   (dbginitReq),
        .i_si            (si),
        .i_se            (se),
        .o_cluster_cken  (clusterCken),
        .o_cluster_grst_l(clusterGrstL),
        .o_dbginit_l     (dbginitL),
        .o_busy          (busy),
        .o_so            (so)
    );

    always #5 gclk = ~gclk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic obs_t mk(logic [3:0] ck, logic [3:0] gl, logic [3:0] dl, logic b);
        obs_t o;
        o.cken   = ck;
        o.grst_l = gl;
        o.dbg_l  = dl;
        o.busy   = b;
        o.so     = ck[3];
        return o;
    endfunction

    function automatic obs_t sampleDut();
        obs_t o;
        o.cken   = clusterCken;
        o.grst_l = clusterGrstL;
        o.dbg_l  = dbginitL;
        o.busy   = busy;
        o.so     = so;
        return o;
    endfunction

    task automatic tick();
        @(posedge gclk);
        #1;
    endtask

    task automatic do_reset();
        grst = 1'b1; ckenReq = 1'b0; clusterMask = 4'b0000;
        dbginitReq = 1'b0; si = 1'b0; se = 1'b0;
        tick();
        tick();
        grst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        obs_t e, a;
        do_reset();
        e = mk(4'b0000, 4'b0000, 4'b1111, 1'b0);
        a = sampleDut();
        nChecks++;
        if (a !== e) begin
            nFail++;
            $display("[TB] FAIL reset_values: got %b want %b", a, e);
        end
        // Abort a ramp part-way with reset, then confirm it stays idle once released.
        ckenReq = 1'b1; clusterMask = 4'b1111;
        for (int n = 0; n < 6; n++) tick();
        expQ.push_back(mk(4'b0000, 4'b0000, 4'b1111, 1'b0));
        expQ.push_back(mk(4'b0000, 4'b0000, 4'b1111, 1'b0));
        grst = 1'b1;
        for (int n = 0; n < 2; n++) begin
            tick();
            if (n == 0) begin grst = 1'b0; ckenReq = 1'b0; end
            e = expQ.pop_front();
            a = sampleDut();
            nChecks++;
            if (a !== e) begin
                nFail++;
                $display("[TB] FAIL reset_midramp step %0d: got %b want %b", n, a, e);
            end
        end
    endtask

    task automatic test_ramp_up();
        obs_t e, a;
        logic [3:0] ck, gl;
        do_reset();
        ckenReq = 1'b1; clusterMask = 4'b1111;
        for (int n = 0; n <= 22; n++) begin
            for (int i = 0; i < 4; i++) begin
                ck[i] = (n >= 1 + 4 * i);
                gl[i] = (n >= 9 + 4 * i);
            end
            expQ.push_back(mk(ck, gl, 4'b1111, n < 17));
        end
        for (int n = 0; n <= 22; n++) begin
            tick();
            e = expQ.pop_front();
            a = sampleDut();
            nChecks++;
            if (a !== e) begin
                nFail++;
                $display("[TB] FAIL ramp_up cycle %0d: got %b want %b", n, a, e);
            end
        end
    endtask

    task automatic test_ramp_down();
        obs_t e, a;
        logic [3:0] ck;
        ckenReq = 1'b0;
        for (int n = 0; n <= 18; n++) begin
            for (int i = 0; i < 4; i++) ck[i] = !(n >= 1 + 4 * (3 - i));
            expQ.push_back(mk(ck, ck, 4'b1111, n < 17));
        end
        for (int n = 0; n <= 18; n++) begin
            tick();
            e = expQ.pop_front();
            a = sampleDut();
            nChecks++;
            if (a !== e) begin
                nFail++;
                $display("[TB] FAIL ramp_down cycle %0d: got %b want %b", n, a, e);
            end
        end
    endtask

    task automatic test_masked();
        obs_t e, a;
        logic [3:0] ck, gl;
        do_reset();
        ckenReq = 1'b1; clusterMask = 4'b1010;
        for (int n = 0; n <= 14; n++) begin
            ck = {n >= 5, 1'b0, n >= 1, 1'b0};
            gl = {n >= 13, 1'b0, n >= 9, 1'b0};
            expQ.push_back(mk(ck, gl, 4'b1111, n < 9));
        end
        for (int n = 0; n <= 14; n++) begin
            tick();
            e = expQ.pop_front();
            a = sampleDut();
            nChecks++;
            if (a !== e) begin
                nFail++;
                $display("[TB] FAIL masked_ramp cycle %0d: got %b want %b", n, a, e);
            end
        end
    endtask

    task automatic test_abort();
        obs_t e, a;
        logic [3:0] ck, gl;
        do_reset();
        ckenReq = 1'b1; clusterMask = 4'b1111;
        for (int n = 0; n <= 19; n++) begin
            ck = {1'b0, 1'b0, (n >= 5 && n < 9), (n >= 1 && n < 13)};
            gl = {1'b0, 1'b0, 1'b0, (n >= 9 && n < 13)};
            expQ.push_back(mk(ck, gl, 4'b1111, n < 17));
        end
        for (int n = 0; n <= 19; n++) begin
            tick();
            e = expQ.pop_front();
            a = sampleDut();
            nChecks++;
            if (a !== e) begin
                nFail++;
                $display("[TB] FAIL abort cycle %0d: got %b want %b", n, a, e);
            end
            if (n == 6) ckenReq = 1'b0;
        end
    endtask

    task automatic test_dbginit();
        obs_t e, a;
        do_reset();
        // A request outside ON must be dropped.
        for (int n = 0; n <= 4; n++) expQ.push_back(mk(4'b0000, 4'b0000, 4'b1111, 1'b0));
        dbginitReq = 1'b1;
        for (int n = 0; n <= 4; n++) begin
            tick();
            dbginitReq = 1'b0;
            e = expQ.pop_front();
            a = sampleDut();
            nChecks++;
            if (a !== e) begin
                nFail++;
                $display("[TB] FAIL dbg_idle_drop cycle %0d: got %b want %b", n, a, e);
            end
        end
        ckenReq = 1'b1; clusterMask = 4'b1111;
        for (int n = 0; n < 22; n++) tick();
        for (int n = 0; n <= 7; n++) begin
            expQ.push_back(mk(4'b1111, 4'b1111, (n >= 1 && n <= 3) ? 4'b0000 : 4'b1111, 1'b0));
        end
        dbginitReq = 1'b1;
        for (int n = 0; n <= 7; n++) begin
            tick();
            dbginitReq = (n == 2);
            e = expQ.pop_front();
            a = sampleDut();
            nChecks++;
            if (a !== e) begin
                nFail++;
                $display("[TB] FAIL dbginit cycle %0d: got %b want %b", n, a, e);
            end
        end
    endtask

    task automatic test_scan();
        obs_t e, a;
        do_reset();
        ckenReq = 1'b1; clusterMask = 4'b0101;
        for (int n = 0; n < 16; n++) tick();
        se = 1'b1; si = 1'b1;
        // Entry state plus four shifts, then resume, ramp-down start, reset and a post-reset shift.
        expQ.push_back(mk(4'b0101, 4'b0101, 4'b1111, 1'b0));
        expQ.push_back(mk(4'b1011, 4'b0101, 4'b1111, 1'b0));
        expQ.push_back(mk(4'b0111, 4'b0101, 4'b1111, 1'b0));
        expQ.push_back(mk(4'b1111, 4'b0101, 4'b1111, 1'b0));
        expQ.push_back(mk(4'b1111, 4'b0101, 4'b1111, 1'b0));
        expQ.push_back(mk(4'b1111, 4'b0101, 4'b1111, 1'b0));
        expQ.push_back(mk(4'b1111, 4'b0101, 4'b1111, 1'b1));
        expQ.push_back(mk(4'b0111, 4'b0101, 4'b1111, 1'b1));
        expQ.push_back(mk(4'b0000, 4'b0000, 4'b1111, 1'b0));
        expQ.push_back(mk(4'b0001, 4'b0000, 4'b1111, 1'b0));
        for (int n = 0; n < 10; n++) begin
            if (n > 0) tick();
            case (n)
                4:       se = 1'b0;
                5:       ckenReq = 1'b0;
                7:       begin se = 1'b1; si = 1'b1; grst = 1'b1; end
                8:       grst = 1'b0;
                default: ;
            endcase
            e = expQ.pop_front();
            a = sampleDut();
            nChecks++;
            if (a !== e) begin
                nFail++;
                $display("[TB] FAIL scan step %0d: got %b want %b", n, a, e);
            end
        end
        se = 1'b0; si = 1'b0;
    endtask

    initial begin
        grst = 1'b1; ckenReq = 1'b0; clusterMask = 4'b0000;
        dbginitReq = 1'b0; si = 1'b0; se = 1'b0;
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_masked();
        test_abort();
        test_dbginit();
        test_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
